// File: rtl/dht11_reader.sv
// DHT11 single-wire poller: periodic start pulse, 40-bit capture, checksum, held outputs.
// Define DHT11_BCD_EN to add saturating BCD copies of humidity/temperature.
module dht11_reader #(
  parameter int unsigned CLK_DIV_US    = 50,
  parameter int unsigned POLL_US       = 2_000_000,
  parameter int unsigned START_LOW_US  = 18_000,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned BIT_THRESH_US = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dht_in,
  output logic       dht_drive_low,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       data_valid,
  output logic       err_checksum,
  output logic       err_timeout,
  output logic       busy
`ifdef DHT11_BCD_EN
  ,
  output logic [7:0] hum_bcd,
  output logic [7:0] temp_bcd
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    RELEASE,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        sync3;
  logic        rise;
  logic        fall;
  logic        tick;
  logic [31:0] div_cnt;
  logic [31:0] us_cnt;
  logic [31:0] us_now;
  logic [39:0] shreg;
  logic [5:0]  bit_cnt;
  logic [7:0]  csum;
  logic        bit_val;
  logic        to_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= dht_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;
  assign tick = (div_cnt == CLK_DIV_US - 1);

  // Elapsed microseconds including the tick landing this cycle.
  assign us_now  = us_cnt + 32'(tick);
  assign to_hit  = tick && (us_now == TIMEOUT_US);
  assign bit_val = (us_now > BIT_THRESH_US);
  assign csum    = shreg[39:32] + shreg[31:24]
                 + shreg[23:16] + shreg[15:8];

`ifdef DHT11_BCD_EN
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    if (v > 8'd99) return 8'h99;
    t = 4'(v / 8'd10);
    o = 4'(v % 8'd10);
    return {t, o};
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      dht_drive_low <= 1'b0;
      humidity      <= '0;
      temperature   <= '0;
      data_valid    <= 1'b0;
      err_checksum  <= 1'b0;
      err_timeout   <= 1'b0;
      busy          <= 1'b0;
      div_cnt       <= '0;
      us_cnt        <= '0;
      shreg         <= '0;
      bit_cnt       <= '0;
`ifdef DHT11_BCD_EN
      hum_bcd       <= '0;
      temp_bcd      <= '0;
`endif
    end else begin
      data_valid   <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        us_cnt  <= us_now;
      end else begin
        div_cnt <= div_cnt + 32'd1;
      end

      unique case (state)
        IDLE: begin
          if (tick && us_now == POLL_US) begin
            state         <= START_LOW;
            dht_drive_low <= 1'b1;
            busy          <= 1'b1;
            div_cnt       <= '0;
            us_cnt        <= '0;
          end
        end
        START_LOW: begin
          if (tick && us_now == START_LOW_US) begin
            state         <= RELEASE;
            dht_drive_low <= 1'b0;
            shreg         <= '0;
            bit_cnt       <= '0;
            div_cnt       <= '0;
            us_cnt        <= '0;
          end
        end
        RELEASE: begin
          if (fall) begin
            state   <= RESP_LOW;
            div_cnt <= '0;
            us_cnt  <= '0;
          end else if (to_hit) begin
            state       <= IDLE;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            div_cnt     <= '0;
            us_cnt      <= '0;
          end
        end
        RESP_LOW: begin
          if (rise) begin
            state   <= RESP_HIGH;
            div_cnt <= '0;
            us_cnt  <= '0;
          end else if (to_hit) begin
            state       <= IDLE;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            div_cnt     <= '0;
            us_cnt      <= '0;
          end
        end
        RESP_HIGH: begin
          if (fall) begin
            state   <= BIT_LOW;
            div_cnt <= '0;
            us_cnt  <= '0;
          end else if (to_hit) begin
            state       <= IDLE;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            div_cnt     <= '0;
            us_cnt      <= '0;
          end
        end
        BIT_LOW: begin
          if (rise) begin
            state   <= BIT_HIGH;
            div_cnt <= '0;
            us_cnt  <= '0;
          end else if (to_hit) begin
            state       <= IDLE;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            div_cnt     <= '0;
            us_cnt      <= '0;
          end
        end
        BIT_HIGH: begin
          if (fall) begin
            shreg   <= {shreg[38:0], bit_val};
            bit_cnt <= bit_cnt + 6'd1;
            state   <= (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
            div_cnt <= '0;
            us_cnt  <= '0;
          end else if (to_hit) begin
            state       <= IDLE;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            div_cnt     <= '0;
            us_cnt      <= '0;
          end
        end
        CHECK: begin
          if (csum == shreg[7:0]) begin
            humidity    <= shreg[39:32];
            temperature <= shreg[23:16];
            data_valid  <= 1'b1;
`ifdef DHT11_BCD_EN
            hum_bcd     <= to_bcd(shreg[39:32]);
            temp_bcd    <= to_bcd(shreg[23:16]);
`endif
          end else begin
            err_checksum <= 1'b1;
          end
          state   <= IDLE;
          busy    <= 1'b0;
          div_cnt <= '0;
          us_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: behavioural DHT11 sensor, byte-level reference model,
// scoreboard queue checked by an independent pulse monitor.
module tb_dht11_reader;

  logic       clk;
  logic       rst_n;
  logic       sensor_line;
  logic       dht_in;
  logic       dht_drive_low;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       data_valid;
  logic       err_checksum;
  logic       err_timeout;
  logic       busy;
`ifdef DHT11_BCD_EN
  logic [7:0] hum_bcd;
  logic [7:0] temp_bcd;
`endif

  assign dht_in = dht_drive_low ? 1'b0 : sensor_line;

  dht11_reader #(
    .CLK_DIV_US(1),
    .POLL_US(100),
    .START_LOW_US(20),
    .TIMEOUT_US(200),
    .BIT_THRESH_US(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dht_in(dht_in),
    .dht_drive_low(dht_drive_low),
    .humidity(humidity),
    .temperature(temperature),
    .data_valid(data_valid),
    .err_checksum(err_checksum),
    .err_timeout(err_timeout),
    .busy(busy)
`ifdef DHT11_BCD_EN
    ,
    .hum_bcd(hum_bcd),
    .temp_bcd(temp_bcd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         dv;
    bit         ec;
    bit         et;
    logic [7:0] hum;
    logic [7:0] tmp;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         ht[40];
  logic [7:0] mhum = 0;
  logic [7:0] mtmp = 0;
  int         idle_run = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input logic [7:0] v);
    if (v > 99) return 8'h99;
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // Clock cycles since the last reset edge or since busy last fell.
  always @(negedge clk)
    idle_run <= !rst_n ? 1 : (busy ? 0 : idle_run + 1);

  always @(negedge clk) begin
    exp_t e;
    if (data_valid || err_checksum || err_timeout) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {data_valid, err_checksum, err_timeout}, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {data_valid, err_checksum, err_timeout},
            {e.dv, e.ec, e.et});
        chk("humidity", humidity, e.hum);
        chk("temperature", temperature, e.tmp);
        chk("busy_after_pulse", busy, 0);
`ifdef DHT11_BCD_EN
        chk("hum_bcd", hum_bcd, bcd(e.hum));
        chk("temp_bcd", temp_bcd, bcd(e.tmp));
`endif
      end
    end
  end

  task automatic fill(input logic [7:0] b0, b1, b2, b3, b4);
    logic [39:0] v;
    v = {b0, b1, b2, b3, b4};
    for (int i = 0; i < 40; i++)
      ht[i] = v[39-i] ? int'($urandom_range(90, 51))
                      : int'($urandom_range(50, 10));
  endtask

  // What a correct reader must report, from the pulse widths alone.
  task automatic model_push(input bit timeout);
    logic [39:0] v;
    logic [7:0]  b[5];
    logic [7:0]  s;
    exp_t        e;
    e.dv = 0;
    e.ec = 0;
    e.et = timeout;
    if (!timeout) begin
      for (int i = 0; i < 40; i++) v[39-i] = (ht[i] > 50);
      for (int k = 0; k < 5; k++) b[k] = v[39-8*k -: 8];
      s = b[0] + b[1] + b[2] + b[3];
      if (s == b[4]) begin
        mhum = b[0];
        mtmp = b[2];
        e.dv = 1;
      end else begin
        e.ec = 1;
      end
    end
    e.hum = mhum;
    e.tmp = mtmp;
    q.push_back(e);
  endtask

  task automatic do_reset_check();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_drive", dht_drive_low, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hum", humidity, 0);
    chk("rst_temp", temperature, 0);
    chk("rst_pulses", {data_valid, err_checksum, err_timeout}, 0);
    mhum = 0;
    mtmp = 0;
    sensor_line = 1'b1;
    #2 rst_n = 1'b1;
  endtask

  task automatic convert(input bit silent, input int rst_bit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dht_drive_low !== 1'b1 && n < 1000);
    if (dht_drive_low !== 1'b1) begin
      chk("start_wait_expired", dht_drive_low, 1);
      return;
    end
    chk("idle_gap", idle_run, 100);
    chk("busy_in_start", busy, 1);
    n = 0;
    while (dht_drive_low === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("start_low_len", n, 20);
    if (silent) begin
      model_push(1);
      n = 0;
      while (err_timeout !== 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_latency", n, 200);
      return;
    end
    repeat ($urandom_range(40, 20)) @(negedge clk);
    sensor_line = 1'b0;
    repeat (80) @(negedge clk);
    sensor_line = 1'b1;
    repeat (80) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      sensor_line = 1'b0;
      repeat ($urandom_range(55, 30)) @(negedge clk);
      sensor_line = 1'b1;
      if (i == rst_bit) begin
        repeat (10) @(negedge clk);
        do_reset_check();
        return;
      end
      repeat (ht[i]) @(negedge clk);
    end
    sensor_line = 1'b0;
    model_push(0);
    repeat (50) @(negedge clk);
    sensor_line = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r2, r4;
    rst_n = 1'b0;
    sensor_line = 1'b1;
    repeat (2) @(negedge clk);
    do_reset_check();

    fill(8'h37, 8'h00, 8'h18, 8'h00, 8'h4E);
    convert(0, -1);
    fill(8'h37, 8'h00, 8'h18, 8'h00, 8'h4F);
    convert(0, -1);
    fill(8'h37, 8'h00, 8'h18, 8'h00, 8'h4E);
    convert(0, -1);
    convert(1, -1);

    fill(8'h08, 8'h00, 8'h14, 8'h00, 8'h1C);
    for (int i = 0; i < 40; i++) ht[i] = (ht[i] > 50) ? 51 : 50;
    convert(0, -1);

    fill(8'h22, 8'h00, 8'h19, 8'h00, 8'h3B);
    convert(0, 20);
    fill(8'h37, 8'h00, 8'h18, 8'h00, 8'h4F);
    convert(0, -1);

    fill(8'h63, 8'h00, 8'h1A, 8'h00, 8'h7D);
    convert(0, -1);

    for (int k = 0; k < 3; k++) begin
      r0 = 8'($urandom);
      r2 = 8'($urandom);
      r4 = r0 + r2;
      if ($urandom_range(1, 0) == 1) r4 = r4 + 8'(1 + $urandom_range(254, 0));
      fill(r0, 8'h00, r2, 8'h00, r4);
      convert(0, -1);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
